mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, byte-lane data memory between the core's instruction-fetch requester and its load/store requester.
- Accepts one request at a time and sequences the fixed-latency memory access.
- Returns read data with a one-cycle acknowledge.
- Sits between mips_core's fetch/load-store paths and the memory model, so one memory instance serves both.

Parameters:
- MEM_LATENCY, 1: cycles the memory needs per access; legal range 1..15.
- MAX_DATA_BURST, 4: maximum consecutive data grants allowed while a fetch is waiting; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_b  input  1  reset; synchronous, active-high. rst_b==1 at a rising edge resets the block.
- halted  input  1  core halted; blocks new grants.
- if_req  input  1  fetch request; held high until if_ack.
- if_addr  input  32  fetch address.
- if_ack  output  1  fetch done; one-cycle pulse.
- if_rdata  output  32  fetched word; valid while if_ack.
- d_req  input  1  data request; held high until d_ack.
- d_we  input  1  data write (1) or read (0).
- d_addr  input  32  data address.
- d_wdata  input  8x4 (unpacked [0:3])  store bytes; index 0 is the MSB.
- d_ack  output  1  data done; one-cycle pulse.
- d_rdata  output  32  load word; valid while d_ack.
- mem_addr  output  32  memory address.
- mem_data_in  output  8x4 [0:3]  memory write bytes.
- mem_write_en  output  1  memory write strobe.
- mem_data_out  input  8x4 [0:3]  memory read bytes.

Behaviour:
- States:
  - IDLE: sample requests; grant when (if_req | d_req) & !halted.
  - ACCESS: drive the latched request for MEM_LATENCY cycles.
  - RESP: pulse the owner's ack.
- Transitions: IDLE->ACCESS on grant; ACCESS->RESP when lat_cnt==MEM_LATENCY-1; RESP->IDLE always.
- Grant rule:
  - Data wins by default.
  - Fetch wins if d_req is low, or if burst_cnt==MAX_DATA_BURST and if_req is high.
- burst_cnt:
  - Increments on each data grant made while if_req is high, saturating at MAX_DATA_BURST.
  - Clears on a fetch grant, or on a data grant made while if_req is low.
- Grant cycle: latch owner, addr, we, wdata; set lat_cnt=0.
  - A fetch grant always sets we=0.
  - The address passes through unchanged; no alignment check.
- ACCESS outputs:
  - mem_addr = latched addr; mem_data_in = latched wdata.
  - mem_write_en = latched we, asserted only in the final ACCESS cycle, so exactly one write per store.
- Final ACCESS cycle: capture {mem_data_out[0..3]} into the read-data register. Stores also capture; that value is don't-care.
- RESP: the owner's ack = 1 for exactly one cycle. The matching rdata holds the captured word and stays stable until the next capture.
- Latency: request high in IDLE at cycle N -> ack at cycle N+MEM_LATENCY+1.
  - Back-to-back throughput is one access per MEM_LATENCY+2 cycles.
- Requester rule: after its ack the requester drops req or presents a new request. A req still high in IDLE is a new request.
- Outside ACCESS: mem_addr = 0, mem_data_in = all-zero bytes, mem_write_en = 0.
- halted:
  - Checked only in IDLE.
  - An access already in flight completes and is acked.
  - No grant while halted is high.
- Simultaneous if_req and d_req in IDLE: the grant rule decides; the loser stays pending with no ack.
- Reset values (including reset mid-access):
  - state = IDLE; lat_cnt = 0; burst_cnt = 0.
  - if_ack = d_ack = 0; if_rdata = d_rdata = 0; mem_write_en = 0; mem_addr = 0.
  - The aborted access is never acked, and no write strobe is issued.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, adds outputs perf_if_grants[31:0], perf_d_grants[31:0] and perf_conflicts[31:0].
  - Each counts grants per requester, or IDLE cycles with both requests high and not halted.
  - Counters wrap at 2^32 and are reset to 0 by rst_b.
- When undefined: no such ports and no counter logic; core behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
  - typedef enum logic {OWN_IF, OWN_D} arb_owner_t;
  - localparam widths for the 4-bit counters.
- Sub-module mem_arb_grant (combinational): inputs if_req, d_req, halted, burst_cnt; outputs grant_valid and grant_owner.

Test Plan:
- Single fetch, MEM_LATENCY=1: if_req=1, if_addr=0x0000_0010, memory returns 0x2108_0005 -> mem_addr=0x10 in cycle N+1, if_ack and if_rdata=0x2108_0005 in cycle N+2, mem_write_en never high.
- Store, MEM_LATENCY=3: d_req=1, d_we=1, d_addr=0x40, d_wdata={8'hDE,8'hAD,8'hBE,8'hEF} -> mem_write_en high exactly in cycle N+3, then d_ack in N+4, memory word 0x40 reads 0xDEADBEEF.
- Fairness, MAX_DATA_BURST=2: if_req and d_req both held high -> grant order D, D, IF, D, D, IF; each ack a single-cycle pulse.
- halted: assert halted during an ACCESS of a load -> that d_ack still arrives; a pending if_req is never acked while halted stays 1.
- Reset mid-access: raise rst_b during the store's ACCESS before its last cycle -> no mem_write_en pulse, no d_ack; outputs 0 next cycle; memory word unchanged.
- With MEM_ARB_PERF_EN: 3 fetches, 2 loads, 1 conflicting cycle -> perf_if_grants=3, perf_d_grants=2, perf_conflicts=1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and counter widths for the memory port arbiter.
// Holds the FSM state encoding and the identity of the access owner.
package mem_arb_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
   typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant decision between fetch and data requesters.
// Data wins unless it is idle or has used up its burst allowance while a fetch waits.
module mem_arb_grant
   import mem_arb_pkg::*;
#(
   parameter int MAX_DATA_BURST = 4
)
(
   input  logic             if_req,
   input  logic             d_req,
   input  logic             halted,
   input  logic [CNT_W-1:0] burst_cnt,
   output logic             grant_valid,
   output arb_owner_t       grant_owner
);

   logic fetch_due;

   always_comb begin
      fetch_due   = if_req && (burst_cnt == CNT_W'(MAX_DATA_BURST));
      grant_valid = (if_req || d_req) && !halted;
      grant_owner = (d_req && !fetch_due) ? OWN_D : OWN_IF;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency, byte-lane memory between instruction fetch and load/store.
// Optional grant/conflict counters are enabled by defining MEM_ARB_PERF_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LATENCY    = 1,
   parameter int MAX_DATA_BURST = 4
)
(
   input  logic        clk,
   input  logic        rst_b,
   input  logic        halted,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [7:0]  d_wdata [0:3],
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic [31:0] mem_addr,
   output logic [7:0]  mem_data_in [0:3],
   output logic        mem_write_en,
   input  logic [7:0]  mem_data_out [0:3],
   output arb_state_t  dbg_state
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0] perf_if_grants,
   output logic [31:0] perf_d_grants,
   output logic [31:0] perf_conflicts
`endif
);

   arb_state_t       state;
   arb_owner_t       owner_q;
   logic [CNT_W-1:0] lat_cnt;
   logic [CNT_W-1:0] burst_cnt;
   logic [31:0]      addr_q;
   logic             we_q;
   logic [7:0]       wdata_q [0:3];
   logic [31:0]      rdata_q;

   logic             grant_valid;
   arb_owner_t       grant_owner;
   logic             in_access;
   logic             last_cycle;

   mem_arb_grant #(
      .MAX_DATA_BURST (MAX_DATA_BURST)
   ) u_grant (
      .if_req      (if_req),
      .d_req       (d_req),
      .halted      (halted),
      .burst_cnt   (burst_cnt),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   assign in_access  = (state == ARB_ACCESS);
   assign last_cycle = in_access && (lat_cnt == CNT_W'(MEM_LATENCY - 1));

   always_ff @(posedge clk) begin
      if (rst_b) begin
         state     <= ARB_IDLE;
         owner_q   <= OWN_IF;
         lat_cnt   <= '0;
         burst_cnt <= '0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '{default: 8'h00};
         rdata_q   <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (grant_valid) begin
                  state   <= ARB_ACCESS;
                  lat_cnt <= '0;
                  owner_q <= grant_owner;
                  addr_q  <= (grant_owner == OWN_D) ? d_addr : if_addr;
                  we_q    <= (grant_owner == OWN_D) && d_we;
                  wdata_q <= d_wdata;
                  // Only data grants that starve a waiting fetch use up the burst allowance.
                  if ((grant_owner == OWN_D) && if_req) begin
                     if (burst_cnt != CNT_W'(MAX_DATA_BURST))
                        burst_cnt <= burst_cnt + CNT_W'(1);
                  end else begin
                     burst_cnt <= '0;
                  end
               end
            end
            ARB_ACCESS: begin
               if (last_cycle) begin
                  rdata_q <= {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};
                  state   <= ARB_RESP;
               end else begin
                  lat_cnt <= lat_cnt + CNT_W'(1);
               end
            end
            ARB_RESP: state <= ARB_IDLE;
            default:  state <= ARB_IDLE;
         endcase
      end
   end

   always_comb begin
      mem_addr     = in_access ? addr_q : 32'h0;
      mem_write_en = last_cycle && we_q;
      for (int i = 0; i < 4; i++)
         mem_data_in[i] = in_access ? wdata_q[i] : 8'h00;
      if_ack    = (state == ARB_RESP) && (owner_q == OWN_IF);
      d_ack     = (state == ARB_RESP) && (owner_q == OWN_D);
      if_rdata  = rdata_q;
      d_rdata   = rdata_q;
      dbg_state = state;
   end

`ifdef MEM_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst_b) begin
         perf_if_grants <= '0;
         perf_d_grants  <= '0;
         perf_conflicts <= '0;
      end else if (state == ARB_IDLE) begin
         if (grant_valid && (grant_owner == OWN_IF)) perf_if_grants <= perf_if_grants + 32'd1;
         if (grant_valid && (grant_owner == OWN_D))  perf_d_grants  <= perf_d_grants + 32'd1;
         if (if_req && d_req && !halted)             perf_conflicts <= perf_conflicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: timestamp-based transaction model, directed scenarios, random traffic.
// Perf counters are checked when MEM_ARB_PERF_EN is defined.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int LAT  = 3;
   localparam int MAXB = 2;

   logic        clk = 1'b0;
   logic        rst_b = 1'b1;
   logic        halted = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'h0;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = 32'h0;
   logic [7:0]  d_wdata [0:3];
   logic        d_ack;
   logic [31:0] d_rdata;
   logic [31:0] mem_addr;
   logic [7:0]  mem_data_in [0:3];
   logic        mem_write_en;
   logic [7:0]  mem_data_out [0:3];
   arb_state_t  dbg_state;
`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_if_grants, perf_d_grants, perf_conflicts;
`endif

   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];
   logic [31:0] rd_word;

   int tests_run    = 0;
   int tests_failed = 0;
   bit checking     = 1'b0;

   mem_port_arbiter #(
      .MEM_LATENCY    (LAT),
      .MAX_DATA_BURST (MAXB)
   ) dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .halted       (halted),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_ack       (if_ack),
      .if_rdata     (if_rdata),
      .d_req        (d_req),
      .d_we         (d_we),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_ack        (d_ack),
      .d_rdata      (d_rdata),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_write_en (mem_write_en),
      .mem_data_out (mem_data_out),
      .dbg_state    (dbg_state)
`ifdef MEM_ARB_PERF_EN
      ,
      .perf_if_grants (perf_if_grants),
      .perf_d_grants  (perf_d_grants),
      .perf_conflicts (perf_conflicts)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, write on the strobe at the rising edge.
   always_comb begin
      rd_word = mem[mem_addr[9:2]];
      mem_data_out[0] = rd_word[31:24];
      mem_data_out[1] = rd_word[23:16];
      mem_data_out[2] = rd_word[15:8];
      mem_data_out[3] = rd_word[7:0];
   end

   always @(posedge clk)
      if (mem_write_en)
         mem[mem_addr[9:2]] = {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};

   function automatic logic [31:0] pack4(input logic [7:0] b [0:3]);
      return {b[0], b[1], b[2], b[3]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a granted transaction at cycle g occupies the memory in
   // cycles g+1..g+LAT, acks in g+LAT+1, and the arbiter samples again at g+LAT+2.
   int          cyc = 0;
   bit          m_busy = 1'b0;
   int          m_g = 0;
   bit          m_own_d = 1'b0;
   bit          m_we = 1'b0;
   logic [31:0] m_addr = 32'h0;
   logic [31:0] m_wdata = 32'h0;
   logic [31:0] m_word = 32'h0;
   int          m_burst = 0;
   int          m_if_grants = 0, m_d_grants = 0, m_conflicts = 0;

   always @(negedge clk) begin
      bit in_acc, e_wen, e_ifack, e_dack;
      in_acc  = m_busy && (cyc > m_g) && (cyc <= m_g + LAT);
      e_wen   = in_acc && m_we && (cyc == m_g + LAT);
      e_ifack = m_busy && !m_own_d && (cyc == m_g + LAT + 1);
      e_dack  = m_busy && m_own_d && (cyc == m_g + LAT + 1);
      if (checking) begin
         chk("mem_addr", mem_addr, in_acc ? m_addr : 32'h0);
         chk("mem_write_en", 32'(mem_write_en), 32'(e_wen));
         if (!in_acc || m_own_d)
            chk("mem_data_in", pack4(mem_data_in), in_acc ? m_wdata : 32'h0);
         chk("if_ack", 32'(if_ack), 32'(e_ifack));
         chk("d_ack", 32'(d_ack), 32'(e_dack));
         if (e_ifack) chk("if_rdata", if_rdata, m_word);
         if (e_dack && !m_we) chk("d_rdata", d_rdata, m_word);
      end
      if (e_wen) ref_mem[m_addr[9:2]] = m_wdata;
      if (rst_b) begin
         m_busy = 1'b0;
         m_burst = 0;
         m_if_grants = 0;
         m_d_grants = 0;
         m_conflicts = 0;
      end else if (m_busy) begin
         if (cyc == m_g + LAT + 1) m_busy = 1'b0;
      end else begin
         if (if_req && d_req && !halted) m_conflicts++;
         if ((if_req || d_req) && !halted) begin
            m_own_d = d_req && !(if_req && (m_burst == MAXB));
            if (m_own_d && if_req) m_burst = (m_burst < MAXB) ? m_burst + 1 : MAXB;
            else                   m_burst = 0;
            if (m_own_d) m_d_grants++; else m_if_grants++;
            m_we    = m_own_d && d_we;
            m_addr  = m_own_d ? d_addr : if_addr;
            m_wdata = pack4(d_wdata);
            m_word  = ref_mem[m_addr[9:2]];
            m_busy  = 1'b1;
            m_g     = cyc;
         end
      end
      cyc++;
   end

   // One complete access with cycle-exact checks; request dropped after the ack.
   task automatic do_op(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input bit want_rd, input logic [31:0] exp_rd);
      @(posedge clk); #1;
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_addr = addr;
         for (int i = 0; i < 4; i++) d_wdata[i] = wd[31-8*i -: 8];
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      for (int k = 0; k <= LAT + 1; k++) begin
         @(negedge clk);
         chk("op mem_addr", mem_addr, (k >= 1 && k <= LAT) ? addr : 32'h0);
         chk("op write strobe", 32'(mem_write_en), 32'(we && (k == LAT)));
         chk("op ack", 32'(is_d ? d_ack : if_ack), 32'(k == LAT + 1));
         if (k == LAT + 1 && want_rd) chk("op rdata", is_d ? d_rdata : if_rdata, exp_rd);
      end
      @(posedge clk); #1;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
   endtask

   initial begin
      int n, guard, cnt, bad, k;
      bit found, ia, da;
      int order [0:5];
      int exp_order [0:5];
      exp_order = '{1, 1, 0, 1, 1, 0};
      for (int i = 0; i < 4; i++) d_wdata[i] = 8'h00;
      for (int i = 0; i < 256; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1 rst_b = 1'b0;
      checking = 1'b1;
      @(negedge clk);
      chk("rst if_ack", 32'(if_ack), 32'h0);
      chk("rst d_ack", 32'(d_ack), 32'h0);
      chk("rst if_rdata", if_rdata, 32'h0);
      chk("rst d_rdata", d_rdata, 32'h0);
      chk("rst mem_write_en", 32'(mem_write_en), 32'h0);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst state", 32'(dbg_state), 32'(ARB_IDLE));

      // Single fetch, store, load-back, unaligned fetch pass-through
      mem[4] = 32'h2108_0005; ref_mem[4] = 32'h2108_0005;
      do_op(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'h2108_0005);
      do_op(1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0);
      chk("store mem word", mem[16], 32'hDEAD_BEEF);
      do_op(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 32'hDEAD_BEEF);
      do_op(1'b0, 1'b0, 32'hFFFF_0013, 32'h0, 1'b1, 32'h2108_0005);

      // Fairness: both requesters held high
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      n = 0; guard = 0;
      while (n < 6 && guard < 6 * (LAT + 2) + 20) begin
         @(negedge clk);
         guard++;
         if (if_ack) begin order[n] = 0; n++; end
         else if (d_ack) begin order[n] = 1; n++; end
      end
      chk("fair ack count", 32'(n), 32'd6);
      for (int i = 0; i < n; i++) chk("fair order", 32'(order[i]), 32'(exp_order[i]));
      @(posedge clk); #1;
      if_req = 1'b0; d_req = 1'b0;

      // halted during a load's access
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
      @(posedge clk); #1;
      @(posedge clk); #1;
      halted = 1'b1; if_req = 1'b1; if_addr = 32'h48;
      found = 1'b0; k = 0;
      for (int i = 0; i < LAT + 4 && !found; i++) begin
         @(negedge clk);
         if (d_ack) begin found = 1'b1; k = i; end
      end
      chk("halt load acked", 32'(found), 32'h1);
      chk("halt load ack offset", 32'(k), 32'(LAT - 1));
      @(posedge clk); #1;
      d_req = 1'b0;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (if_ack) cnt++;
      end
      chk("halt no fetch ack", 32'(cnt), 32'h0);
      chk("halt state idle", 32'(dbg_state), 32'(ARB_IDLE));
      @(posedge clk); #1;
      halted = 1'b0;
      found = 1'b0;
      for (int i = 0; i < LAT + 4 && !found; i++) begin
         @(negedge clk);
         if (if_ack) found = 1'b1;
      end
      chk("unhalt fetch acked", 32'(found), 32'h1);
      @(posedge clk); #1;
      if_req = 1'b0;

      // Reset in the middle of a store
      mem[32] = 32'hCAFE_F00D; ref_mem[32] = 32'hCAFE_F00D;
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80;
      d_wdata[0] = 8'h11; d_wdata[1] = 8'h22; d_wdata[2] = 8'h33; d_wdata[3] = 8'h44;
      cnt = 0;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      @(posedge clk); #1;
      rst_b = 1'b1;
      @(negedge clk);
      if (mem_write_en || d_ack) cnt++;
      @(posedge clk); #1;
      rst_b = 1'b0; d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      chk("abort mem_addr", mem_addr, 32'h0);
      chk("abort d_rdata", d_rdata, 32'h0);
      chk("abort if_rdata", if_rdata, 32'h0);
      chk("abort state", 32'(dbg_state), 32'(ARB_IDLE));
      repeat (LAT + 3) begin
         @(negedge clk);
         if (mem_write_en || d_ack) cnt++;
      end
      chk("abort no strobe or ack", 32'(cnt), 32'h0);
      chk("abort mem unchanged", mem[32], 32'hCAFE_F00D);

      // Random traffic
      ia = 1'b0; da = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         ia = if_ack; da = d_ack;
         @(posedge clk); #1;
         if (!if_req || ia) begin
            if_req = ($urandom_range(0, 3) != 0);
            if_addr = $urandom;
         end
         if (!d_req || da) begin
            d_req = ($urandom_range(0, 3) != 0);
            d_we = $urandom_range(0, 1) != 0;
            d_addr = $urandom;
            for (int i = 0; i < 4; i++) d_wdata[i] = 8'($urandom_range(0, 255));
         end
         halted = ($urandom_range(0, 9) == 0);
         rst_b = ($urandom_range(0, 399) == 0);
      end
      @(negedge clk);
      @(posedge clk); #1;
      if_req = 1'b0; d_req = 1'b0; halted = 1'b0; rst_b = 1'b0;
      repeat (LAT + 4) @(negedge clk);

      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk("memory image", 32'(bad), 32'h0);
`ifdef MEM_ARB_PERF_EN
      chk("perf_if_grants", perf_if_grants, 32'(m_if_grants));
      chk("perf_d_grants", perf_d_grants, 32'(m_d_grants));
      chk("perf_conflicts", perf_conflicts, 32'(m_conflicts));
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
